// File: rtl/icache_set_assoc_if.sv
// rtl/icache_set_assoc_if.sv - IFU fetch port and AXI4 read channels of the set-associative icache
// slave modport is the cache; master is the IFU plus read fabric around it.
interface icache_set_assoc_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  resp_valid;
  logic [31:0]           resp_data;
  logic                  resp_err;
  logic                  fence_i;
  logic                  miss_pulse;

  logic [ADDR_WIDTH-1:0] M_AXI_ARADDR;
  logic                  M_AXI_ARVALID;
  logic                  M_AXI_ARREADY;
  logic [3:0]            M_AXI_ARID;
  logic [7:0]            M_AXI_ARLEN;
  logic [2:0]            M_AXI_ARSIZE;
  logic [1:0]            M_AXI_ARBURST;
  logic [31:0]           M_AXI_RDATA;
  logic [1:0]            M_AXI_RRESP;
  logic                  M_AXI_RLAST;
  logic [3:0]            M_AXI_RID;
  logic                  M_AXI_RVALID;
  logic                  M_AXI_RREADY;

  modport slave (
    input  req_valid, req_addr, fence_i,
    output req_ready, resp_valid, resp_data, resp_err, miss_pulse,
    output M_AXI_ARADDR, M_AXI_ARVALID, M_AXI_ARID, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST,
    input  M_AXI_ARREADY,
    input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RID, M_AXI_RVALID,
    output M_AXI_RREADY
  );

  modport master (
    output req_valid, req_addr, fence_i,
    input  req_ready, resp_valid, resp_data, resp_err, miss_pulse,
    input  M_AXI_ARADDR, M_AXI_ARVALID, M_AXI_ARID, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST,
    output M_AXI_ARREADY,
    output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RID, M_AXI_RVALID,
    input  M_AXI_RREADY
  );
endinterface

// File: rtl/icache_set_assoc.sv
// rtl/icache_set_assoc.sv - set-associative instruction cache with round-robin replacement and AXI4 burst refill
// Fence requests arriving while busy are deferred and applied on the transition back to IDLE.
module icache_set_assoc #(
  parameter int ADDR_WIDTH     = 32,
  parameter int SETS           = 4,
  parameter int WAYS           = 2,
  parameter int WORDS_PER_LINE = 8
) (
  input logic                clk_i,
  input logic                rst_i,
  icache_set_assoc_if.slave  bus
);
  localparam int OFF_W  = $clog2(WORDS_PER_LINE * 4);
  localparam int WOFF_W = $clog2(WORDS_PER_LINE);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_WIDTH - OFF_W - IDX_W;
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_AR, S_R, S_RESP} state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [WAYS-1:0]       valid_q [SETS];
  logic [TAG_W-1:0]      tag_q   [SETS][WAYS];
  logic [31:0]           data_q  [SETS][WAYS][WORDS_PER_LINE];
  logic [WAY_W-1:0]      rr_q    [SETS];
  logic [WAY_W-1:0]      victim_q;
  logic                  victim_rr_q;
  logic [WOFF_W-1:0]     beat_q;
  logic                  err_q, fence_pend_q;
  logic                  req_ready_q, resp_valid_q, resp_err_q, miss_q, arvalid_q, rready_q;
  logic [31:0]           resp_data_q;

  logic [WOFF_W-1:0] off;
  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  assign off = addr_q[OFF_W-1:2];
  assign idx = addr_q[OFF_W+IDX_W-1:OFF_W];
  assign tag = addr_q[ADDR_WIDTH-1:OFF_W+IDX_W];

  logic             hit, victim_rr_d, beat_err_d, last_err_d;
  logic [31:0]      hit_word;
  logic [WAY_W-1:0] victim_d;

  always_comb begin
    hit         = 1'b0;
    hit_word    = '0;
    victim_d    = rr_q[idx];
    victim_rr_d = 1'b1;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
        hit      = 1'b1;
        hit_word = data_q[idx][w][off];
      end
    end
    // Descending scan so the lowest invalid way wins.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[idx][w]) begin
        victim_d    = WAY_W'(w);
        victim_rr_d = 1'b0;
      end
    end
  end

  assign beat_err_d = err_q | (bus.M_AXI_RRESP != 2'b00);
  assign last_err_d = beat_err_d | (beat_q != WOFF_W'(WORDS_PER_LINE - 1));

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (state_q == S_LOOKUP && !hit) tag_q[idx][victim_d] <= tag;
      if (state_q == S_R && bus.M_AXI_RVALID) data_q[idx][victim_q][beat_q] <= bus.M_AXI_RDATA;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      victim_q     <= '0;
      victim_rr_q  <= 1'b0;
      beat_q       <= '0;
      err_q        <= 1'b0;
      fence_pend_q <= 1'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
      miss_q       <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else begin
      resp_valid_q <= 1'b0;
      miss_q       <= 1'b0;
      if (bus.fence_i && state_q != S_IDLE) fence_pend_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (bus.fence_i) begin
            for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
          end else if (bus.req_valid) begin
            addr_q      <= bus.req_addr;
            req_ready_q <= 1'b0;
            state_q     <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (hit) begin
            resp_valid_q <= 1'b1;
            resp_data_q  <= hit_word;
            resp_err_q   <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= S_IDLE;
            if (fence_pend_q || bus.fence_i) begin
              for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
              fence_pend_q <= 1'b0;
            end
          end else begin
            miss_q               <= 1'b1;
            victim_q             <= victim_d;
            victim_rr_q          <= victim_rr_d;
            valid_q[idx][victim_d] <= 1'b0;
            err_q                <= 1'b0;
            beat_q               <= '0;
            arvalid_q            <= 1'b1;
            state_q              <= S_AR;
          end
        end
        S_AR: begin
          if (bus.M_AXI_ARREADY) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= S_R;
          end
        end
        S_R: begin
          if (bus.M_AXI_RVALID) begin
            beat_q <= beat_q + WOFF_W'(1);
            err_q  <= beat_err_d;
            if (bus.M_AXI_RLAST) begin
              // A short burst leaves part of the line stale, so it is reported as an error.
              err_q        <= last_err_d;
              beat_q       <= '0;
              rready_q     <= 1'b0;
              resp_valid_q <= 1'b1;
              resp_err_q   <= last_err_d;
              resp_data_q  <= (beat_q == off) ? bus.M_AXI_RDATA : data_q[idx][victim_q][off];
              state_q      <= S_RESP;
            end
          end
        end
        S_RESP: begin
          if (!err_q) valid_q[idx][victim_q] <= 1'b1;
          if (victim_rr_q) rr_q[idx] <= (WAYS > 1) ? rr_q[idx] + WAY_W'(1) : '0;
          req_ready_q <= 1'b1;
          state_q     <= S_IDLE;
          if (fence_pend_q || bus.fence_i) begin
            for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
            fence_pend_q <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready     = req_ready_q & ~bus.fence_i;
  assign bus.resp_valid    = resp_valid_q;
  assign bus.resp_data     = resp_data_q;
  assign bus.resp_err      = resp_err_q;
  assign bus.miss_pulse    = miss_q;
  assign bus.M_AXI_ARADDR  = {addr_q[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
  assign bus.M_AXI_ARVALID = arvalid_q;
  assign bus.M_AXI_ARID    = 4'd0;
  assign bus.M_AXI_ARLEN   = 8'(WORDS_PER_LINE - 1);
  assign bus.M_AXI_ARSIZE  = 3'b010;
  assign bus.M_AXI_ARBURST = 2'b01;
  assign bus.M_AXI_RREADY  = rready_q;

  logic unused_ok;
  assign unused_ok = ^{bus.M_AXI_RID, addr_q[1:0]};
endmodule

// File: tb/tb_icache_set_assoc.sv
// tb/tb_icache_set_assoc.sv - directed vector bench for icache_set_assoc with a burst memory responder
// Memory word at byte address a reads as a + 0x1000_0001.
module tb_icache_set_assoc;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  icache_set_assoc_if #(.ADDR_WIDTH(32)) bus ();

  icache_set_assoc #(
    .ADDR_WIDTH(32), .SETS(4), .WAYS(2), .WORDS_PER_LINE(8)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] addr;
    int          err_beat;
    int          last_beat;
    int          ar_delay;
    bit          fence_r;
    bit          fence_idle;
    bit          exp_miss;
    logic [31:0] exp_data;
    bit          exp_err;
  } vec_t;

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!bus.req_ready && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) check({name, "_ready_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int cyc, ar_cycles, ar_cnt, miss_cnt, beat_idx;
    bit ar_done, beat_active, fence_done, got;
    logic [31:0] araddr, line;
    logic [7:0]  arlen;
    cyc = 0; ar_cycles = 0; ar_cnt = 0; miss_cnt = 0; beat_idx = 0;
    ar_done = 0; beat_active = 0; fence_done = 0; got = 0;
    araddr = '0; arlen = '0; line = '0;
    wait_ready(name);
    if (v.fence_idle) begin
      bus.fence_i = 1'b1;
      #1;
      check({name, "_fence_ready"}, {31'd0, bus.req_ready}, 32'd0);
      step();
      bus.fence_i = 1'b0;
      #1;
    end
    bus.req_valid = 1'b1;
    bus.req_addr  = v.addr;
    step();
    bus.req_valid = 1'b0;
    while (cyc < 200 && !got) begin
      cyc++;
      if (bus.resp_valid) begin
        got = 1;
        check({name, "_data"}, bus.resp_data, v.exp_data);
        check({name, "_err"}, {31'd0, bus.resp_err}, {31'd0, v.exp_err});
        bus.M_AXI_RVALID = 1'b0;
        bus.M_AXI_RLAST  = 1'b0;
        bus.fence_i      = 1'b0;
      end else begin
        if (bus.miss_pulse) miss_cnt++;
        bus.M_AXI_ARREADY = 1'b0;
        if (bus.M_AXI_ARVALID && !ar_done) begin
          ar_cycles++;
          if (ar_cycles > v.ar_delay) begin
            bus.M_AXI_ARREADY = 1'b1;
            araddr = bus.M_AXI_ARADDR;
            arlen  = bus.M_AXI_ARLEN;
            line   = bus.M_AXI_ARADDR;
            ar_cnt++;
            ar_done = 1;
            beat_active = 1;
          end
        end
        bus.fence_i = (v.fence_r && beat_idx == 3 && !fence_done) ? 1'b1 : 1'b0;
        if (bus.fence_i) fence_done = 1;
        if (beat_active && bus.M_AXI_RREADY) begin
          bus.M_AXI_RVALID = 1'b1;
          bus.M_AXI_RDATA  = line + 32'(4 * beat_idx) + 32'h1000_0001;
          bus.M_AXI_RRESP  = (beat_idx == v.err_beat) ? 2'b10 : 2'b00;
          bus.M_AXI_RLAST  = (beat_idx == v.last_beat);
          if (beat_idx == v.last_beat) beat_active = 0;
          beat_idx++;
        end else begin
          bus.M_AXI_RVALID = 1'b0;
          bus.M_AXI_RLAST  = 1'b0;
        end
        step();
      end
    end
    if (!got) check({name, "_resp_timeout"}, 32'd1, 32'd0);
    check({name, "_miss_pulses"}, 32'(miss_cnt), {31'd0, v.exp_miss});
    check({name, "_ar_count"}, 32'(ar_cnt), {31'd0, v.exp_miss});
    if (v.exp_miss) begin
      check({name, "_araddr"}, araddr, v.addr & 32'hFFFF_FFE0);
      check({name, "_arlen"}, {24'd0, arlen}, 32'd7);
    end else begin
      check({name, "_hit_latency"}, 32'(cyc), 32'd2);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] a, input bit miss, input logic [31:0] d,
                              input bit err = 0, input int err_beat = -1, input int last_beat = 7,
                              input int ar_delay = 0, input bit fence_r = 0, input bit fence_idle = 0);
    vec_t v;
    v.addr = a; v.exp_miss = miss; v.exp_data = d; v.exp_err = err;
    v.err_beat = err_beat; v.last_beat = last_beat; v.ar_delay = ar_delay;
    v.fence_r = fence_r; v.fence_idle = fence_idle;
    return v;
  endfunction

  vec_t vecs [$];

  initial begin
    bus.req_valid = 1'b0; bus.req_addr = '0; bus.fence_i = 1'b0;
    bus.M_AXI_ARREADY = 1'b0; bus.M_AXI_RDATA = '0; bus.M_AXI_RRESP = 2'b00;
    bus.M_AXI_RLAST = 1'b0; bus.M_AXI_RID = 4'd0; bus.M_AXI_RVALID = 1'b0;

    vecs.push_back(mk(32'h8000_0000, 1, 32'h9000_0001));
    vecs.push_back(mk(32'h8000_0004, 0, 32'h9000_0005));
    vecs.push_back(mk(32'h8000_0080, 1, 32'h9000_0081, 0, -1, 7, 3));
    vecs.push_back(mk(32'h8000_001C, 0, 32'h9000_001D));
    vecs.push_back(mk(32'h8000_0100, 1, 32'h9000_0101));
    vecs.push_back(mk(32'h8000_0084, 0, 32'h9000_0085));
    vecs.push_back(mk(32'h8000_0000, 1, 32'h9000_0001));
    vecs.push_back(mk(32'h8000_0104, 0, 32'h9000_0105));
    vecs.push_back(mk(32'h8000_0020, 1, 32'h9000_0021, 1, 3));
    vecs.push_back(mk(32'h8000_0020, 1, 32'h9000_0021));
    vecs.push_back(mk(32'h8000_0024, 0, 32'h9000_0025));
    vecs.push_back(mk(32'h8000_0040, 1, 32'h9000_0041, 0, -1, 7, 0, 1));
    vecs.push_back(mk(32'h8000_0040, 1, 32'h9000_0041));
    vecs.push_back(mk(32'h8000_002C, 1, 32'h9000_002D));
    vecs.push_back(mk(32'h8000_006C, 1, 32'h9000_006D));
    vecs.push_back(mk(32'h8000_00FC, 1, 32'h9000_00FD));
    vecs.push_back(mk(32'h8000_0060, 0, 32'h9000_0061));
    vecs.push_back(mk(32'h8000_00E4, 0, 32'h9000_00E5));
    vecs.push_back(mk(32'h8000_0064, 1, 32'h9000_0065, 0, -1, 7, 0, 0, 1));
    vecs.push_back(mk(32'h8000_0120, 1, 32'h9000_0121, 1, -1, 3));
    vecs.push_back(mk(32'h8000_0120, 1, 32'h9000_0121));
    vecs.push_back(mk(32'h8000_0068, 0, 32'h9000_0069));

    repeat (3) step();
    rst = 1'b0;
    check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    check("rst_resp_err", {31'd0, bus.resp_err}, 32'd0);
    check("rst_arvalid", {31'd0, bus.M_AXI_ARVALID}, 32'd0);
    check("rst_rready", {31'd0, bus.M_AXI_RREADY}, 32'd0);
    check("rst_miss", {31'd0, bus.miss_pulse}, 32'd0);
    check("const_ar", {bus.M_AXI_ARID, bus.M_AXI_ARSIZE, bus.M_AXI_ARBURST},
          {4'd0, 3'b010, 2'b01});
    step();

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset while the AR request is being held off.
    begin
      int n = 0;
      int ar_seen = 0;
      wait_ready("rst_mid");
      bus.req_valid = 1'b1;
      bus.req_addr  = 32'h8000_00A0;
      step();
      bus.req_valid = 1'b0;
      while (ar_seen < 5 && n < 50) begin
        if (bus.M_AXI_ARVALID) ar_seen++;
        n++;
        step();
      end
      check("rst_mid_ar_held", 32'(ar_seen), 32'd5);
      rst = 1'b1;
      step();
      check("rst_mid_arvalid", {31'd0, bus.M_AXI_ARVALID}, 32'd0);
      check("rst_mid_req_ready", {31'd0, bus.req_ready}, 32'd1);
      rst = 1'b0;
      step();
    end
    run_vec(mk(32'h8000_0068, 1, 32'h9000_0069), "post_rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
